// File: rtl/apb_master_n.sv
// APB master bridge: turns one-cycle CPU requests into APB transfers on one of
// NUM_SLV address-decoded slaves, with a decode-error path and an ACCESS timeout.
`timescale 1ns/1ps
module apb_master_n #(
  parameter int          NUM_SLV     = 4,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          REGION_BITS = 12,
  parameter int          TIMEOUT     = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  transfer,
  input  logic                  write,
  input  logic [31:0]           addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic                  ready,
  output logic                  error,
  output logic [31:0]           PADDR,
  output logic                  PWRITE,
  output logic [31:0]           PWDATA,
  output logic                  PENABLE,
  output logic [NUM_SLV-1:0]    PSEL,
  input  logic [NUM_SLV*32-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]    PREADY,
  input  logic [NUM_SLV-1:0]    PSLVERR
);

  localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_DECERR
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        paddr_q, paddr_d;
  logic               pwrite_q, pwrite_d;
  logic [31:0]        pwdata_q, pwdata_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [31:0]        offset;
  logic [31:0]        idx_full;
  logic               decode_err;
  logic               sel_ready;
  logic               sel_err;
  logic [31:0]        sel_rdata;
  logic               timeout_hit;

  // Region index is computed on the full 32-bit offset so that far-out
  // addresses cannot alias back into a valid slave after truncation.
  assign offset     = addr - BASE_ADDR;
  assign idx_full   = offset >> REGION_BITS;
  assign decode_err = (addr < BASE_ADDR) || (idx_full >= 32'(NUM_SLV));

  assign sel_ready   = PREADY[idx_q];
  assign sel_err     = PSLVERR[idx_q];
  assign sel_rdata   = PRDATA[{idx_q, 5'b0} +: 32];
  assign timeout_hit = (TIMEOUT > 0) && (cnt_q == CNT_LAST) && !sel_ready;

  // NOTE: every output and next-state signal gets a default before the case;
  // any path that skips an assignment would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    ready    = 1'b0;
    error    = 1'b0;
    rdata    = '0;
    PSEL     = '0;
    PENABLE  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (transfer) begin
          paddr_d  = addr;
          pwrite_d = write;
          pwdata_d = wdata;
          idx_d    = idx_full[IDX_W-1:0];
          state_d  = decode_err ? ST_DECERR : ST_SETUP;
        end
      end
      ST_SETUP: begin
        PSEL[idx_q] = 1'b1;
        cnt_d       = '0;
        state_d     = ST_ACCESS;
      end
      ST_ACCESS: begin
        PSEL[idx_q] = 1'b1;
        PENABLE     = 1'b1;
        if (sel_ready) begin
          ready   = 1'b1;
          error   = sel_err;
          rdata   = pwrite_q ? 32'h0 : sel_rdata;
          state_d = ST_IDLE;
        end else if (timeout_hit) begin
          ready   = 1'b1;
          error   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DECERR: begin
        ready   = 1'b1;
        error   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state_q  <= ST_IDLE;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
    end
  end

  assign PADDR  = paddr_q;
  assign PWRITE = pwrite_q;
  assign PWDATA = pwdata_q;

endmodule
